// File: rtl/pic_core_param.sv
// pic_core_param: clocked 8259A-style interrupt controller core with N_IRQ request channels.
// Define PIC_ROTATE_EN to add the rotating lowest-priority pointer.
module pic_core_param #(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] ir,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             inta,
    output logic             int_o,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid
);

    localparam logic [4:0] LAST_CH = 5'(N_IRQ - 1);

    typedef struct packed {
        logic       found;
        logic [4:0] ch;
    } pick_t;

    // Position of a channel in the priority order; 0 is highest. lp is the lowest-priority channel.
    function automatic logic [4:0] rank(input logic [4:0] ch, input logic [4:0] lp);
        int r;
        r = int'(ch) - int'(lp) - 1;
        if (r < 0) r += N_IRQ;
        return 5'(r);
    endfunction

    function automatic pick_t pick(input logic [N_IRQ-1:0] v, input logic [4:0] lp);
        pick_t      p;
        logic [4:0] best;
        p    = '0;
        best = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (v[i] && (!p.found || rank(5'(i), lp) < best)) begin
                p.found = 1'b1;
                p.ch    = 5'(i);
                best    = rank(5'(i), lp);
            end
        end
        return p;
    endfunction

    logic [N_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [N_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
    logic [VEC_W-1:0] base_q, base_d, vec_q, vec_d;
    logic [1:0]       mode_q, mode_d;
    logic             int_o_q, int_o_d, vec_valid_q, vec_valid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [4:0]       lp;

`ifdef PIC_ROTATE_EN
    logic [4:0] lp_q, lp_d;
    assign lp = lp_q;
`else
    assign lp = LAST_CH;
`endif

    pick_t            cand, svc;
    logic             cmd_wr, ack_hit;
    logic [4:0]       cmd_ch;
    logic [N_IRQ-1:0] ack_mask, eoi_mask, edge_set;
    logic [31:0]      base_ext;
    logic             unused_wdata;

    assign cmd_wr       = wr_en && (addr == 2'd3);
    assign cmd_ch       = wdata[12:8];
    assign base_ext     = 32'(base_q);
    assign unused_wdata = ^wdata;

    always_comb begin
        sync1_d = ir;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // All decisions this cycle use pre-write register values.
        cand    = pick(irr_q & ~imr_q, lp);
        svc     = pick(isr_q, lp);
        ack_hit = inta && cand.found;

        ack_mask = '0;
        eoi_mask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_mask[i] = ack_hit && (cand.ch == 5'(i));
            if (cmd_wr && wdata[0] && svc.found && (svc.ch == 5'(i))) eoi_mask[i] = 1'b1;
            if (cmd_wr && wdata[1] && (cmd_ch == 5'(i)))              eoi_mask[i] = 1'b1;
        end
        edge_set = sync2_q & ~prev_q;

        // Sets are OR'd in last so they win over same-cycle clears.
        irr_d = mode_q[0] ? sync2_q : ((irr_q & ~ack_mask) | edge_set);
        isr_d = (isr_q & ~eoi_mask) | (mode_q[1] ? '0 : ack_mask);

        int_o_d = cand.found && (!svc.found || (rank(cand.ch, lp) < rank(svc.ch, lp)));

        vec_valid_d = inta;
        vec_d       = vec_q;
        if (inta) vec_d = base_q + (cand.found ? VEC_W'(cand.ch) : VEC_W'(N_IRQ - 1));

        imr_d  = imr_q;
        base_d = base_q;
        mode_d = mode_q;
        if (wr_en) begin
            case (addr)
                2'd0:    imr_d  = wdata[N_IRQ-1:0];
                2'd1:    base_d = wdata[VEC_W-1:0];
                2'd2:    mode_d = wdata[1:0];
                default: ;
            endcase
        end

`ifdef PIC_ROTATE_EN
        lp_d = lp_q;
        if (cmd_wr && wdata[0] && svc.found) lp_d = svc.ch;
        if (cmd_wr && wdata[2] && (int'(cmd_ch) < N_IRQ)) lp_d = cmd_ch;
`endif

        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = 32'(imr_q);
                2'd1:    rdata_d = 32'(irr_q);
                2'd2:    rdata_d = 32'(isr_q);
                default: rdata_d = {16'b0, base_ext[7:0], 6'b0, mode_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= '1;
            base_q      <= '0;
            mode_q      <= '0;
            int_o_q     <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            rdata_q     <= '0;
`ifdef PIC_ROTATE_EN
            lp_q        <= LAST_CH;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            base_q      <= base_d;
            mode_q      <= mode_d;
            int_o_q     <= int_o_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            rdata_q     <= rdata_d;
`ifdef PIC_ROTATE_EN
            lp_q        <= lp_d;
`endif
        end
    end

    assign rdata     = rdata_q;
    assign int_o     = int_o_q;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;

endmodule
